// File: rtl/tcdm_bank_responder.sv
// Single-port TCDM memory bank: byte-enabled writes, fixed-latency reads, in-order responses.
// Requests are credited against a response buffer so a stalled consumer never loses a response.
module tcdm_bank_responder #(
    parameter int DW        = 32,
    parameter int AW        = 13,
    parameter int IW        = 8,
    parameter int UW        = 1,
    parameter int LATENCY   = 1,
    parameter int RSP_DEPTH = 2
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic                                   clear_i,
    input  logic                                   req_i,
    output logic                                   gnt_o,
    input  logic [AW-1:0]                          add_i,
    input  logic                                   wen_i,
    input  logic [DW-1:0]                          data_i,
    input  logic [DW/8-1:0]                        be_i,
    input  logic [UW-1:0]                          user_i,
    input  logic [IW-1:0]                          id_i,
    output logic                                   r_valid_o,
    input  logic                                   r_ready_i,
    output logic [DW-1:0]                          r_data_o,
    output logic [IW-1:0]                          r_id_o,
    output logic [UW-1:0]                          r_user_o,
    output logic                                   r_opc_o,
    output logic [$clog2(RSP_DEPTH+LATENCY+1)-1:0] occupancy_o
);
    localparam int NW = 2**(AW-2);
    localparam int BW = DW/8;
    localparam int OW = $clog2(RSP_DEPTH+LATENCY+1);
    localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CW = $clog2(RSP_DEPTH+1);

    logic [DW-1:0] r_mem [NW];
    logic [OW-1:0] r_occ;
    logic [PW-1:0] r_wptr, r_rptr;
    logic [CW-1:0] r_fcnt;
    logic [DW-1:0] r_fdata [RSP_DEPTH];
    logic [IW-1:0] r_fid   [RSP_DEPTH];
    logic [UW-1:0] r_fuser [RSP_DEPTH];

    logic          w_req_hs, w_pop, w_push;
    logic [AW-3:0] w_idx;
    logic [DW-1:0] w_s_data, w_push_data;
    logic [IW-1:0] w_push_id;
    logic [UW-1:0] w_push_user;
    logic          w_unused_addr;

    assign w_idx         = add_i[AW-1:2];
    assign w_unused_addr = ^add_i[1:0];
    assign gnt_o         = !clear_i && (r_occ < OW'(RSP_DEPTH));
    assign w_req_hs      = req_i && gnt_o;
    assign r_valid_o     = (r_fcnt != '0);
    assign w_pop         = r_valid_o && r_ready_i;
    assign w_s_data      = wen_i ? r_mem[w_idx] : '0;
    assign occupancy_o   = r_occ;

    // Memory is deliberately left out of reset and clear.
    always_ff @(posedge clk_i) begin
        if (w_req_hs && !wen_i) begin
            for (int b = 0; b < BW; b++) begin
                if (be_i[b]) r_mem[w_idx][b*8 +: 8] <= data_i[b*8 +: 8];
            end
        end
    end

    generate
        if (LATENCY == 1) begin : g_direct
            assign w_push      = w_req_hs;
            assign w_push_data = w_s_data;
            assign w_push_id   = id_i;
            assign w_push_user = user_i;
        end else begin : g_pipe
            logic          r_pv [LATENCY-1];
            logic [DW-1:0] r_pd [LATENCY-1];
            logic [IW-1:0] r_pi [LATENCY-1];
            logic [UW-1:0] r_pu [LATENCY-1];

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    for (int s = 0; s < LATENCY-1; s++) begin
                        r_pv[s] <= 1'b0;
                        r_pd[s] <= '0;
                        r_pi[s] <= '0;
                        r_pu[s] <= '0;
                    end
                end else if (clear_i) begin
                    for (int s = 0; s < LATENCY-1; s++) r_pv[s] <= 1'b0;
                end else begin
                    r_pv[0] <= w_req_hs;
                    r_pd[0] <= w_s_data;
                    r_pi[0] <= id_i;
                    r_pu[0] <= user_i;
                    for (int s = 1; s < LATENCY-1; s++) begin
                        r_pv[s] <= r_pv[s-1];
                        r_pd[s] <= r_pd[s-1];
                        r_pi[s] <= r_pi[s-1];
                        r_pu[s] <= r_pu[s-1];
                    end
                end
            end

            assign w_push      = r_pv[LATENCY-2];
            assign w_push_data = r_pd[LATENCY-2];
            assign w_push_id   = r_pi[LATENCY-2];
            assign w_push_user = r_pu[LATENCY-2];
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_occ  <= '0;
            r_wptr <= '0;
            r_rptr <= '0;
            r_fcnt <= '0;
        end else if (clear_i) begin
            r_occ  <= '0;
            r_wptr <= '0;
            r_rptr <= '0;
            r_fcnt <= '0;
        end else begin
            r_occ  <= r_occ + OW'(w_req_hs) - OW'(w_pop);
            r_fcnt <= r_fcnt + CW'(w_push) - CW'(w_pop);
            if (w_push) r_wptr <= (r_wptr == PW'(RSP_DEPTH-1)) ? '0 : r_wptr + 1'b1;
            if (w_pop)  r_rptr <= (r_rptr == PW'(RSP_DEPTH-1)) ? '0 : r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_fdata[r_wptr] <= w_push_data;
            r_fid[r_wptr]   <= w_push_id;
            r_fuser[r_wptr] <= w_push_user;
        end
    end

    assign r_data_o = r_fdata[r_rptr];
    assign r_id_o   = r_fid[r_rptr];
    assign r_user_o = r_fuser[r_rptr];
    assign r_opc_o  = 1'b0;

    // Credit rule must keep the buffer from ever being pushed while full.
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(w_push && !w_pop && (r_fcnt == CW'(RSP_DEPTH))));
    a_occ_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
        r_occ <= OW'(RSP_DEPTH));

endmodule

// File: tb/tb_tcdm_bank_responder.sv
// Bench for tcdm_bank_responder: directed vector table, corner sequences, and a
// randomized stream checked against a queue-based model of the bank.
module tb_tcdm_bank_responder;
    localparam int LAT   = 1;
    localparam int DEPTH = 2;

    logic        clk_i = 1'b0;
    logic        rst_ni, clear_i, req_i, gnt_o, wen_i;
    logic [12:0] add_i;
    logic [31:0] data_i, r_data_o;
    logic [3:0]  be_i;
    logic [0:0]  user_i, r_user_o;
    logic [7:0]  id_i, r_id_o;
    logic        r_valid_o, r_ready_i, r_opc_o;
    logic [1:0]  occupancy_o;

    tcdm_bank_responder #(.DW(32), .AW(13), .IW(8), .UW(1), .LATENCY(LAT), .RSP_DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .req_i(req_i), .gnt_o(gnt_o),
        .add_i(add_i), .wen_i(wen_i), .data_i(data_i), .be_i(be_i), .user_i(user_i), .id_i(id_i),
        .r_valid_o(r_valid_o), .r_ready_i(r_ready_i), .r_data_o(r_data_o), .r_id_o(r_id_o),
        .r_user_o(r_user_o), .r_opc_o(r_opc_o), .occupancy_o(occupancy_o));

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: flat word memory with per-byte "known" flags, plus an
    // ordered queue of outstanding responses stamped with their grant cycle.
    typedef struct {
        int          cyc;
        logic [7:0]  id;
        logic [0:0]  user;
        logic [31:0] data;
        logic [31:0] mask;
    } rsp_t;

    rsp_t        q[$];
    logic [31:0] m_mem   [2048];
    logic [3:0]  m_known [2048];
    int          cyc = 0;

    task automatic monitor();
        rsp_t  e;
        int    w;
        logic  exp_v;
        cyc++;
        if (!rst_ni) begin
            q.delete();
            for (int i = 0; i < 2048; i++) m_known[i] = 4'h0;
            return;
        end
        chk("occupancy", occupancy_o, q.size());
        chk("occ_bound", occupancy_o <= DEPTH, 1);
        exp_v = (q.size() > 0) && (cyc >= q[0].cyc + LAT);
        chk("r_valid", r_valid_o, exp_v);
        if (clear_i) begin
            q.delete();
            return;
        end
        if (r_valid_o && r_ready_i) begin
            if (q.size() == 0) begin
                chk("unexpected_rsp", 1, 0);
            end else begin
                e = q.pop_front();
                chk("rsp_id", r_id_o, e.id);
                chk("rsp_user", r_user_o, e.user);
                chk("rsp_data", r_data_o & e.mask, e.data & e.mask);
                chk("rsp_opc", r_opc_o, 0);
            end
        end
        if (req_i && gnt_o) begin
            w = int'(add_i[12:2]);
            e.cyc = cyc; e.id = id_i; e.user = user_i;
            if (!wen_i) begin
                for (int b = 0; b < 4; b++) begin
                    if (be_i[b]) begin
                        m_mem[w][b*8 +: 8] = data_i[b*8 +: 8];
                        m_known[w][b] = 1'b1;
                    end
                end
                e.data = 32'h0;
                e.mask = 32'hFFFF_FFFF;
            end else begin
                e.data = m_mem[w];
                for (int b = 0; b < 4; b++) e.mask[b*8 +: 8] = {8{m_known[w][b]}};
            end
            q.push_back(e);
        end
    endtask

    task automatic to_neg();
        @(negedge clk_i);
        monitor();
    endtask

    task automatic to_drive();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic req, input logic wen, input logic [12:0] add,
                         input logic [31:0] d, input logic [3:0] be, input logic [7:0] id,
                         input logic [0:0] u, input logic rdy);
        req_i = req; wen_i = wen; add_i = add; data_i = d; be_i = be;
        id_i = id; user_i = u; r_ready_i = rdy;
    endtask

    typedef struct {
        logic        req, wen;
        logic [12:0] add;
        logic [31:0] d;
        logic [3:0]  be;
        logic [7:0]  id;
        logic [0:0]  u;
        logic        rdy;
        logic        e_gnt, e_vld;
        logic [31:0] e_data;
        logic [7:0]  e_id;
        logic [0:0]  e_u;
        logic [1:0]  e_occ;
    } vec_t;

    vec_t tbl[11];

    initial begin
        int          grants, k, lim;
        logic [31:0] cap_d;
        logic [7:0]  cap_id;
        logic [12:0] addrs[4];

        tbl[0]  = '{1'b0, 1'b1, 13'h00, 32'h0,         4'h0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         8'd0, 1'b0, 2'd0};
        tbl[1]  = '{1'b1, 1'b0, 13'h10, 32'hDEADBEEF,  4'hF, 8'd1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         8'd0, 1'b0, 2'd0};
        tbl[2]  = '{1'b1, 1'b1, 13'h10, 32'h0,         4'h0, 8'd5, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0,         8'd1, 1'b0, 2'd1};
        tbl[3]  = '{1'b0, 1'b1, 13'h00, 32'h0,         4'h0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF,  8'd5, 1'b1, 2'd1};
        tbl[4]  = '{1'b1, 1'b0, 13'h20, 32'h11223344,  4'hF, 8'd2, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         8'd0, 1'b0, 2'd0};
        tbl[5]  = '{1'b1, 1'b0, 13'h20, 32'hAABBCCDD,  4'h5, 8'd3, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0,         8'd2, 1'b0, 2'd1};
        tbl[6]  = '{1'b1, 1'b1, 13'h20, 32'h0,         4'h0, 8'd4, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0,         8'd3, 1'b1, 2'd1};
        tbl[7]  = '{1'b0, 1'b1, 13'h00, 32'h0,         4'h0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h11BB33DD,  8'd4, 1'b0, 2'd1};
        tbl[8]  = '{1'b1, 1'b1, 13'h13, 32'h0,         4'h0, 8'd6, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         8'd0, 1'b0, 2'd0};
        tbl[9]  = '{1'b0, 1'b1, 13'h00, 32'h0,         4'h0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF,  8'd6, 1'b1, 2'd1};
        tbl[10] = '{1'b0, 1'b1, 13'h00, 32'h0,         4'h0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         8'd0, 1'b0, 2'd0};

        rst_ni = 1'b0; clear_i = 1'b0;
        drive(1'b0, 1'b1, 13'h0, 32'h0, 4'h0, 8'd0, 1'b0, 1'b1);
        repeat (2) begin to_neg(); to_drive(); end
        chk("reset_valid", r_valid_o, 0);
        chk("reset_occ", occupancy_o, 0);
        rst_ni = 1'b1;

        // Directed vectors: write/read, byte-enable merge, read-after-write, ignored low address bits.
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].req, tbl[i].wen, tbl[i].add, tbl[i].d, tbl[i].be, tbl[i].id, tbl[i].u, tbl[i].rdy);
            to_neg();
            chk($sformatf("vec%0d_gnt", i), gnt_o, tbl[i].e_gnt);
            chk($sformatf("vec%0d_valid", i), r_valid_o, tbl[i].e_vld);
            chk($sformatf("vec%0d_occ", i), occupancy_o, tbl[i].e_occ);
            if (tbl[i].e_vld) begin
                chk($sformatf("vec%0d_data", i), r_data_o, tbl[i].e_data);
                chk($sformatf("vec%0d_id", i), r_id_o, tbl[i].e_id);
                chk($sformatf("vec%0d_user", i), r_user_o, tbl[i].e_u);
                chk($sformatf("vec%0d_opc", i), r_opc_o, 0);
            end
            to_drive();
        end

        // Back-to-back reads with ready held high: no grant bubbles.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, (i % 2 == 0) ? 13'h10 : 13'h20, 32'h0, 4'h0, 8'(40 + i), 1'(i), 1'b1);
            to_neg();
            chk("b2b_gnt", gnt_o, 1);
            to_drive();
        end
        drive(1'b0, 1'b1, 13'h0, 32'h0, 4'h0, 8'd0, 1'b0, 1'b1);
        repeat (2) begin to_neg(); to_drive(); end

        // Stalled consumer: credits run out after DEPTH grants, head stays stable.
        addrs[0] = 13'h10; addrs[1] = 13'h20; addrs[2] = 13'h11; addrs[3] = 13'h22;
        grants = 0; k = 0; cap_d = 32'h0; cap_id = 8'h0;
        for (int c = 0; c < 6; c++) begin
            drive(1'b1, 1'b1, addrs[k], 32'h0, 4'h0, 8'(10 + k), 1'b0, 1'b0);
            to_neg();
            if (c == 2) begin cap_d = r_data_o; cap_id = r_id_o; end
            if (gnt_o) begin grants++; k++; end
            to_drive();
        end
        to_neg();
        chk("stall_grants", grants, 2);
        chk("stall_gnt", gnt_o, 0);
        chk("stall_occ", occupancy_o, 2);
        chk("stall_valid", r_valid_o, 1);
        chk("stall_id", r_id_o, 8'd10);
        chk("stall_id_stable", r_id_o, cap_id);
        chk("stall_data_stable", r_data_o, cap_d);
        to_drive();
        lim = 0;
        while (k < 4 && lim < 20) begin
            drive(1'b1, 1'b1, addrs[k], 32'h0, 4'h0, 8'(10 + k), 1'b0, 1'b1);
            to_neg();
            if (gnt_o) begin grants++; k++; end
            to_drive();
            lim++;
        end
        chk("release_grants", grants, 4);
        drive(1'b0, 1'b1, 13'h0, 32'h0, 4'h0, 8'd0, 1'b0, 1'b1);
        lim = 0;
        while (q.size() != 0 && lim < 20) begin to_neg(); to_drive(); lim++; end
        chk("release_drained", q.size(), 0);

        // Clear with two responses buffered; memory must survive.
        drive(1'b1, 1'b1, 13'h10, 32'h0, 4'h0, 8'd20, 1'b0, 1'b0); to_neg(); to_drive();
        drive(1'b1, 1'b1, 13'h20, 32'h0, 4'h0, 8'd21, 1'b0, 1'b0); to_neg(); to_drive();
        drive(1'b0, 1'b1, 13'h0,  32'h0, 4'h0, 8'd0,  1'b0, 1'b0); to_neg();
        chk("preclear_valid", r_valid_o, 1);
        chk("preclear_occ", occupancy_o, 2);
        to_drive();
        clear_i = 1'b1; to_neg(); to_drive();
        drive(1'b1, 1'b1, 13'h20, 32'h0, 4'h0, 8'd99, 1'b0, 1'b0);
        to_neg();
        chk("clear_gnt", gnt_o, 0);
        chk("clear_valid", r_valid_o, 0);
        chk("clear_occ", occupancy_o, 0);
        to_drive();
        clear_i = 1'b0;
        drive(1'b1, 1'b1, 13'h20, 32'h0, 4'h0, 8'd22, 1'b1, 1'b1); to_neg(); to_drive();
        drive(1'b0, 1'b1, 13'h0, 32'h0, 4'h0, 8'd0, 1'b0, 1'b1);
        to_neg();
        chk("postclear_valid", r_valid_o, 1);
        chk("postclear_id", r_id_o, 8'd22);
        chk("postclear_data", r_data_o, 32'h11BB33DD);
        to_drive();
        to_neg(); to_drive();

        // Asynchronous reset pulse between clock edges, mid-stream.
        drive(1'b1, 1'b1, 13'h10, 32'h0, 4'h0, 8'd30, 1'b0, 1'b0); to_neg(); to_drive();
        drive(1'b1, 1'b1, 13'h20, 32'h0, 4'h0, 8'd31, 1'b0, 1'b0); to_neg(); to_drive();
        drive(1'b0, 1'b1, 13'h0,  32'h0, 4'h0, 8'd0,  1'b0, 1'b0); to_neg();
        chk("prerst_valid", r_valid_o, 1);
        to_drive();
        #1 rst_ni = 1'b0;
        #1;
        chk("async_rst_valid", r_valid_o, 0);
        chk("async_rst_occ", occupancy_o, 0);
        chk("async_rst_gnt", gnt_o, 1);
        to_neg();
        #2 rst_ni = 1'b1;
        to_drive();
        r_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            to_neg();
            chk("postrst_no_stale", r_valid_o, 0);
            to_drive();
        end

        // Random stream against the model.
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b0, 13'(i * 4), $urandom, 4'hF, 8'(i), 1'b0, 1'b1);
            to_neg(); to_drive();
        end
        k = 0; lim = 0;
        while (k < 10000 && lim < 60000) begin
            drive(($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)),
                  13'({4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))}),
                  $urandom, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 7));
            to_neg();
            if (req_i && gnt_o) k++;
            to_drive();
            lim++;
        end
        chk("random_grants", k, 10000);
        drive(1'b0, 1'b1, 13'h0, 32'h0, 4'h0, 8'd0, 1'b0, 1'b1);
        lim = 0;
        while (q.size() != 0 && lim < 50) begin to_neg(); to_drive(); lim++; end
        chk("random_drained", q.size(), 0);
        to_neg();
        chk("final_occ", occupancy_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/tcdm_bank_responder.md
TCDM_BANK_RESPONDER -- requirements
Module: tcdm_bank_responder

Interface
REQ-001 SHALL have parameter DW, default 32: data width in bits.
REQ-002 SHALL have parameter AW, default 13: byte address width; the bank holds 2**(AW-2) words.
REQ-003 SHALL have parameter IW, default 8: request/response ID width.
REQ-004 SHALL have parameter UW, default 1: user sideband width.
REQ-005 SHALL have parameter LATENCY, default 1 (legal range 1..4): cycles from grant to earliest response.
REQ-006 SHALL have parameter RSP_DEPTH, default 2 (≥1): response buffer entries.
REQ-007 SHALL have ports: clk_i in 1 clock; rst_ni in 1 asynchronous active-low reset; clear_i in 1 synchronous flush.
REQ-008 SHALL have ports: req_i in 1 request valid; gnt_o out 1 grant; add_i in AW byte address; wen_i in 1 (1=read, 0=write); data_i in DW write data; be_i in DW/8 byte enables; user_i in UW; id_i in IW.
REQ-009 SHALL have ports: r_valid_o out 1; r_ready_i in 1; r_data_o out DW; r_id_o out IW; r_user_o out UW; r_opc_o out 1 (error flag).
REQ-010 SHALL have port occupancy_o out $clog2(RSP_DEPTH+LATENCY+1): outstanding-transaction count, for debug and verification.

Function
REQ-011 SHALL accept a request in a cycle iff req_i && gnt_o (a handshake).
REQ-012 SHALL drive gnt_o = !clear_i && (occupancy_o < RSP_DEPTH), combinationally; occupancy counts in-flight pipeline stages plus buffered responses.
REQ-013 SHALL decrement the occupancy counter when the response handshake r_valid_o && r_ready_i occurs, and increment it on a request handshake; if both occur in the same cycle, the count is unchanged.
REQ-014 SHALL compute the word index as add_i[AW-1:2]; add_i[1:0] is ignored.
REQ-015 SHALL perform a write at the handshake edge: only bytes with be_i=1 are updated; the write response carries r_data_o=0.
REQ-016 SHALL sample read data at the handshake edge and return it LATENCY cycles later through a pipeline of valid/id/user/data stages.
REQ-017 SHALL give a read issued in the cycle after a write to the same word the updated data (no stale read).
REQ-018 SHALL produce exactly one response per granted request, both reads and writes, in strict request order.
REQ-019 SHALL return r_id_o and r_user_o equal to the id_i and user_i of the matching request.
REQ-020 SHALL drive r_opc_o to 0 for all responses; the bit is reserved.
REQ-021 SHALL push each pipeline output into a FIFO of RSP_DEPTH entries; r_valid_o = FIFO not empty; output data is taken from the FIFO head.
REQ-022 SHALL hold r_data_o/r_id_o/r_user_o stable while r_valid_o=1 and r_ready_i=0.
REQ-023 SHALL never overflow the FIFO; this is guaranteed by the REQ-012 credit rule, and an assertion flags any violation.
REQ-024 SHALL, on clear_i=1, empty the pipeline and FIFO, zero occupancy, and force gnt_o=0 in that cycle; memory contents are unchanged.
REQ-025 SHALL, with RSP_DEPTH=2, LATENCY=1 and r_ready_i tied to 1, sustain one request per cycle with no grant bubbles.

Reset
REQ-026 SHALL, on rst_ni=0 at any time including mid-transaction, immediately clear r_valid_o, occupancy_o, pipeline valids and the FIFO pointers, with no clock required.
REQ-027 SHALL, after reset, drive gnt_o=1 once req_i is presented, provided clear_i=0.
REQ-028 SHALL NOT reset the memory array; its contents after reset are undefined.

Verification
REQ-029 Write 0xDEADBEEF to add 0x10 with be=0xF, then read 0x10 with id=5, r_ready=1 → write response with r_data=0, then read response with r_data=0xDEADBEEF and r_id=5, LATENCY cycles after its grant.
REQ-030 Write 0x11223344 to 0x20, then write 0xAABBCCDD with be=0x5, then read → r_data=0x11BB33DD.
REQ-031 Hold r_ready=0 and issue 4 back-to-back reads with RSP_DEPTH=2 → exactly 2 grants, then gnt_o=0 and occupancy=2; release r_ready → remaining 2 grants follow, and the 4 responses arrive in order with stable data while stalled.
REQ-032 Assert clear_i with 2 responses buffered → next cycle r_valid_o=0 and occupancy_o=0; a subsequent read returns the data written before the clear.
REQ-033 Pulse rst_ni low mid-stream, asynchronously between clock edges → r_valid_o falls at once; no response from before the reset appears afterwards.
REQ-034 Random streams of req and r_ready (10k transactions) checked against a scoreboard → one response per grant, in order, with id/user/data matching, and occupancy never exceeding RSP_DEPTH.
